// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe move sequencer: owns the board, validates move requests, and latches
// the checker's verdict one cycle after each committed move.
module ttt_move_ctrl #(
    parameter logic FIRST_SYM = 1'b1,
    parameter int   TIMEOUT   = 0,
    parameter int   TW        = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       new_game_i,
    input  logic       move_valid_i,
    input  logic [3:0] move_pos_i,
    output logic       move_ready_o,
    output logic [8:0] valid_o,
    output logic [8:0] symbol_o,
    input  logic [1:0] game_state_i,
    output logic [1:0] prev_game_state_o,
    output logic       turn_o,
    output logic [3:0] move_count_o,
    output logic       illegal_o,
    output logic       timeout_o,
    output logic       game_over_o
);
    // state | meaning
    // WAIT  | accepting a move, turn timer running
    // EVAL  | board just changed, checker verdict sampled this cycle
    // OVER  | result latched, board frozen until new game
    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [8:0]    valid_q, valid_d;
    logic [8:0]    symbol_q, symbol_d;
    logic [1:0]    result_q, result_d;
    logic          turn_q, turn_d;
    logic [3:0]    count_q, count_d;
    logic          illegal_q, illegal_d;
    logic          timeout_q, timeout_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [8:0] pos_onehot;
    logic       legal;
    logic       expire;

    // Out-of-range positions shift the one-hot off the end, so they never alias a cell.
    assign pos_onehot = 9'b1 << move_pos_i;
    assign legal      = (move_pos_i <= 4'd8) && ((valid_q & pos_onehot) == 9'b0);

    generate
        if (TIMEOUT > 0) begin : g_timer
            assign expire = (timer_q == TW'(TIMEOUT - 1));
        end else begin : g_no_timer
            assign expire = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        symbol_d  = symbol_q;
        result_d  = result_q;
        turn_d    = turn_q;
        count_d   = count_q;
        timer_d   = timer_q;
        illegal_d = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            S_WAIT: begin
                if (move_valid_i) begin
                    if (legal) begin
                        valid_d  = valid_q | pos_onehot;
                        symbol_d = turn_q ? (symbol_q | pos_onehot) : (symbol_q & ~pos_onehot);
                        count_d  = (count_q == 4'd9) ? count_q : count_q + 4'd1;
                        turn_d   = ~turn_q;
                        timer_d  = '0;
                        state_d  = S_EVAL;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end else if (expire) begin
                    timeout_d = 1'b1;
                    turn_d    = ~turn_q;
                    timer_d   = '0;
                end else if (TIMEOUT > 0) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_EVAL: begin
                if (game_state_i != 2'b00) begin
                    result_d = game_state_i;
                    state_d  = S_OVER;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_OVER: begin
            end
            default: state_d = S_WAIT;
        endcase

        if (new_game_i) begin
            state_d   = S_WAIT;
            valid_d   = '0;
            symbol_d  = '0;
            result_d  = 2'b00;
            turn_d    = FIRST_SYM;
            count_d   = '0;
            timer_d   = '0;
            illegal_d = 1'b0;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_WAIT;
            valid_q   <= '0;
            symbol_q  <= '0;
            result_q  <= 2'b00;
            turn_q    <= FIRST_SYM;
            count_q   <= '0;
            timer_q   <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            symbol_q  <= symbol_d;
            result_q  <= result_d;
            turn_q    <= turn_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign move_ready_o      = (state_q == S_WAIT) && rst_n_i;
    assign valid_o           = valid_q;
    assign symbol_o          = symbol_q;
    assign prev_game_state_o = result_q;
    assign turn_o            = turn_q;
    assign move_count_o      = count_q;
    assign illegal_o         = illegal_q;
    assign timeout_o         = timeout_q;
    assign game_over_o       = (state_q == S_OVER);
endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Bench for ttt_move_ctrl: directed table, corner sequences and random play against
// a board-level reference model; a checker model closes the game_state loop.
module tb_ttt_move_ctrl;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       new_game, move_valid;
    logic [3:0] move_pos;

    logic       ready1, turn1, ill1, to1, over1;
    logic [8:0] valid1, sym1;
    logic [1:0] gs1, pgs1;
    logic [3:0] cnt1;

    logic       ready0, turn0, ill0, to0, over0;
    logic [8:0] valid0, sym0;
    logic [1:0] gs0, pgs0;
    logic [3:0] cnt0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    int LINES[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    // Checker model driving the DUT's game_state input from the DUT's board.
    function automatic logic [1:0] judge_vec(logic [8:0] v, logic [8:0] s);
        for (int l = 0; l < 8; l++) begin
            if (v[LINES[l][0]] && v[LINES[l][1]] && v[LINES[l][2]]) begin
                if (s[LINES[l][0]] && s[LINES[l][1]] && s[LINES[l][2]]) return 2'b01;
                if (!s[LINES[l][0]] && !s[LINES[l][1]] && !s[LINES[l][2]]) return 2'b10;
            end
        end
        return (&v) ? 2'b11 : 2'b00;
    endfunction

    assign gs1 = judge_vec(valid1, sym1);
    assign gs0 = judge_vec(valid0, sym0);

    ttt_move_ctrl #(.FIRST_SYM(1'b1), .TIMEOUT(TO), .TW(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .new_game_i(new_game),
        .move_valid_i(move_valid), .move_pos_i(move_pos), .move_ready_o(ready1),
        .valid_o(valid1), .symbol_o(sym1), .game_state_i(gs1),
        .prev_game_state_o(pgs1), .turn_o(turn1), .move_count_o(cnt1),
        .illegal_o(ill1), .timeout_o(to1), .game_over_o(over1));

    ttt_move_ctrl #(.FIRST_SYM(1'b1), .TIMEOUT(0), .TW(16)) dut_nt (
        .clk_i(clk), .rst_n_i(rst_n), .new_game_i(new_game),
        .move_valid_i(move_valid), .move_pos_i(move_pos), .move_ready_o(ready0),
        .valid_o(valid0), .symbol_o(sym0), .game_state_i(gs0),
        .prev_game_state_o(pgs0), .turn_o(turn0), .move_count_o(cnt0),
        .illegal_o(ill0), .timeout_o(to0), .game_over_o(over0));

    // Reference model: board as cells 0=empty 1=X 2=O, game phase as a small enum.
    typedef enum {PH_PLAY, PH_JUDGE, PH_DONE} phase_t;
    int     m_board[9];
    bit     m_turn, m_ill, m_to, m_rst;
    int     m_count, m_idle;
    logic [1:0] m_result;
    phase_t m_phase;

    function automatic logic [1:0] judge_board();
        for (int l = 0; l < 8; l++) begin
            int a = m_board[LINES[l][0]];
            if (a != 0 && a == m_board[LINES[l][1]] && a == m_board[LINES[l][2]])
                return (a == 1) ? 2'b01 : 2'b10;
        end
        for (int i = 0; i < 9; i++) if (m_board[i] == 0) return 2'b00;
        return 2'b11;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_board[i] = 0;
        m_turn = 1'b1; m_count = 0; m_idle = 0; m_ill = 0; m_to = 0;
        m_result = 2'b00; m_phase = PH_PLAY;
    endtask

    task automatic model_edge(bit mv, int pos, bit ng);
        m_ill = 0; m_to = 0;
        if (ng) begin
            model_reset();
        end else if (m_phase == PH_PLAY) begin
            if (mv) begin
                if (pos <= 8 && m_board[pos] == 0) begin
                    m_board[pos] = m_turn ? 1 : 2;
                    m_count++; m_turn = ~m_turn; m_idle = 0; m_phase = PH_JUDGE;
                end else begin
                    m_ill = 1;
                end
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_to = 1; m_turn = ~m_turn; m_idle = 0;
                end
            end
        end else if (m_phase == PH_JUDGE) begin
            logic [1:0] r = judge_board();
            if (r != 2'b00) begin
                m_result = r; m_phase = PH_DONE;
            end else begin
                m_phase = PH_PLAY;
            end
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [8:0] ev, es;
        for (int i = 0; i < 9; i++) begin
            ev[i] = (m_board[i] != 0);
            es[i] = (m_board[i] == 1);
        end
        chk("valid", 32'(valid1), 32'(ev));
        chk("symbol", 32'(sym1 & valid1), 32'(es));
        chk("move_ready", 32'(ready1), 32'(m_phase == PH_PLAY && !m_rst));
        chk("turn", 32'(turn1), 32'(m_turn));
        chk("move_count", 32'(cnt1), 32'(m_count));
        chk("illegal", 32'(ill1), 32'(m_ill));
        chk("timeout", 32'(to1), 32'(m_to));
        chk("game_over", 32'(over1), 32'(m_phase == PH_DONE));
        chk("prev_game_state", 32'(pgs1), 32'(m_result));
        chk("timeout_disabled", 32'(to0), 32'(0));
    endtask

    task automatic step(bit mv, logic [3:0] pos, bit ng);
        move_valid = mv; move_pos = pos; new_game = ng;
        @(posedge clk);
        model_edge(mv, int'(pos), ng);
        #1;
        compare_all();
        move_valid = 1'b0; new_game = 1'b0;
    endtask

    typedef struct {
        bit mv; logic [3:0] pos;
        logic [8:0] e_valid; logic [3:0] e_cnt;
        bit e_rdy; bit e_turn; bit e_ill; bit e_over; logic [1:0] e_pgs;
    } vec_t;
    vec_t tbl[14];

    int pulses;
    int draw_seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

    initial begin
        tbl[0]  = '{1, 4'd0,  9'b000000001, 4'd1, 0, 0, 0, 0, 2'b00};
        tbl[1]  = '{0, 4'd0,  9'b000000001, 4'd1, 1, 0, 0, 0, 2'b00};
        tbl[2]  = '{1, 4'd3,  9'b000001001, 4'd2, 0, 1, 0, 0, 2'b00};
        tbl[3]  = '{0, 4'd0,  9'b000001001, 4'd2, 1, 1, 0, 0, 2'b00};
        tbl[4]  = '{1, 4'd1,  9'b000001011, 4'd3, 0, 0, 0, 0, 2'b00};
        tbl[5]  = '{0, 4'd0,  9'b000001011, 4'd3, 1, 0, 0, 0, 2'b00};
        tbl[6]  = '{1, 4'd4,  9'b000011011, 4'd4, 0, 1, 0, 0, 2'b00};
        tbl[7]  = '{0, 4'd0,  9'b000011011, 4'd4, 1, 1, 0, 0, 2'b00};
        tbl[8]  = '{1, 4'd4,  9'b000011011, 4'd4, 1, 1, 1, 0, 2'b00};
        tbl[9]  = '{1, 4'd9,  9'b000011011, 4'd4, 1, 1, 1, 0, 2'b00};
        tbl[10] = '{1, 4'd15, 9'b000011011, 4'd4, 1, 1, 1, 0, 2'b00};
        tbl[11] = '{1, 4'd2,  9'b000011111, 4'd5, 0, 0, 0, 0, 2'b00};
        tbl[12] = '{0, 4'd0,  9'b000011111, 4'd5, 0, 0, 0, 1, 2'b01};
        tbl[13] = '{1, 4'd5,  9'b000011111, 4'd5, 0, 0, 0, 1, 2'b01};

        rst_n = 1'b0; new_game = 1'b0; move_valid = 1'b0; move_pos = 4'd0;
        model_reset(); m_rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1; m_rst = 0;
        #1;
        chk("ready_after_reset", 32'(ready1), 32'(1));

        // X takes the top row while O plays 3,4, with illegal probes in between.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].mv, tbl[i].pos, 1'b0);
            chk("tbl_valid", 32'(valid1), 32'(tbl[i].e_valid));
            chk("tbl_count", 32'(cnt1), 32'(tbl[i].e_cnt));
            chk("tbl_ready", 32'(ready1), 32'(tbl[i].e_rdy));
            chk("tbl_turn", 32'(turn1), 32'(tbl[i].e_turn));
            chk("tbl_illegal", 32'(ill1), 32'(tbl[i].e_ill));
            chk("tbl_over", 32'(over1), 32'(tbl[i].e_over));
            chk("tbl_pgs", 32'(pgs1), 32'(tbl[i].e_pgs));
        end

        step(1'b0, 4'd0, 1'b1);
        chk("ng_over_valid", 32'(valid1), 32'(0));
        chk("ng_over_pgs", 32'(pgs1), 32'(0));
        chk("ng_over_ready", 32'(ready1), 32'(1));
        chk("ng_over_turn", 32'(turn1), 32'(1));

        for (int i = 0; i < 9; i++) begin
            step(1'b1, 4'(draw_seq[i]), 1'b0);
            step(1'b0, 4'd0, 1'b0);
        end
        chk("draw_pgs", 32'(pgs1), 32'(3));
        chk("draw_count", 32'(cnt1), 32'(9));
        chk("draw_over", 32'(over1), 32'(1));
        step(1'b1, 4'd3, 1'b0);
        chk("over_no_illegal", 32'(ill1), 32'(0));

        step(1'b0, 4'd0, 1'b1);
        step(1'b1, 4'd4, 1'b0);
        step(1'b0, 4'd0, 1'b1);
        chk("ng_eval_valid", 32'(valid1), 32'(0));
        chk("ng_eval_count", 32'(cnt1), 32'(0));
        chk("ng_eval_ready", 32'(ready1), 32'(1));

        // Async reset while the move at cell 4 is being evaluated.
        step(1'b1, 4'd4, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        model_reset(); m_rst = 1;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1; m_rst = 0;
        #1;
        chk("rst_eval_ready", 32'(ready1), 32'(1));
        chk("rst_eval_turn", 32'(turn1), 32'(1));
        step(1'b0, 4'd0, 1'b0);

        step(1'b0, 4'd0, 1'b1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 4'd0, 1'b0);
            pulses += int'(to1);
        end
        chk("timeout_pulses", 32'(pulses), 32'(3));
        chk("timeout_turn", 32'(turn1), 32'(0));
        chk("timeout_board", 32'(valid1), 32'(0));
        repeat (3) step(1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd8, 1'b0);
        chk("expiry_move_no_to", 32'(to1), 32'(0));
        chk("expiry_move_count", 32'(cnt1), 32'(1));
        step(1'b0, 4'd0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            bit mv, ng;
            logic [3:0] p;
            mv = ($urandom_range(0, 3) != 0);
            p  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            ng = ($urandom_range(0, 39) == 0);
            if (i % 97 == 50) begin
                mv = 1'b0;
            end
            step(mv, p, ng);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
